// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK
// bus levels and the width of the per-byte bit counter.
package i2c_slave_pkg;

  localparam int BIT_CNT_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, followed by a
// previous-value register so rising/falling edges come out as 1-cycle
// pulses aligned with the synchronized level.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resync the pin and keep last cycle's value; reset to the idle-high bus
  // level so leaving reset never fabricates an edge on a quiet bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target. SCL/SDA are oversampled by clk; bus bits are
// sampled on synchronized SCL rises and the slave only moves SDA on
// synchronized SCL falls. SDA is open-drain (0 or z); SCL is never driven.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       rd_req,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       rw,
  output logic       busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [6:0]             shift;
  logic                   sda_low;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .din   (scl),
    .level (scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sda),
    .level (sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SDA moving while SCL is high is a bus condition, never a data bit.
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  // Open-drain output: the register only ever requests a low.
  assign sda = sda_low ? 1'b0 : 1'bz;

  // Protocol FSM with all outputs registered. In the ACK states sda_low
  // doubles as the phase flag: clear = waiting for the fall that starts
  // the ACK, set = waiting for the fall that ends it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      sda_low    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      rd_req     <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      rd_req     <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift <= {shift[5:0], sda_s};
              if (bit_cnt == BIT_CNT_W'(7)) begin
                bit_cnt <= '0;
                // shift still holds the 7 address bits; sda_s is R/W
                if (shift == SLAVE_ADDR) begin
                  rw    <= sda_s;
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= ~I2C_ACK;
                busy    <= 1'b1;
              end else if (rw) begin
                shift   <= tx_data[6:0];
                rd_req  <= 1'b1;
                sda_low <= ~tx_data[7];
                bit_cnt <= BIT_CNT_W'(1);
                state   <= ST_RD_DATA;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_WR_DATA;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              shift <= {shift[5:0], sda_s};
              if (bit_cnt == BIT_CNT_W'(7)) begin
                data_out   <= {shift, sda_s};
                data_valid <= 1'b1;
                bit_cnt    <= '0;
                state      <= ST_WR_ACK;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= ~I2C_ACK;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_WR_DATA;
              end
            end
          end

          // bit_cnt counts bits already placed on the bus; bit 7 went out
          // when the byte was loaded.
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == BIT_CNT_W'(8)) begin
                sda_low <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_low <= ~shift[6];
                shift   <= {shift[5:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end

          // bit_cnt==1 marks that the master's ACK has been seen.
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) begin
                busy  <= 1'b0;
                state <= ST_IGNORE;
              end else begin
                bit_cnt <= BIT_CNT_W'(1);
              end
            end else if (scl_fall && bit_cnt == BIT_CNT_W'(1)) begin
              shift   <= tx_data[6:0];
              rd_req  <= 1'b1;
              sda_low <= ~tx_data[7];
              bit_cnt <= BIT_CNT_W'(1);
              state   <= ST_RD_DATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master on an open-drain
// bus with pull-up, a table of single-byte write transactions, and
// hand-written sequences for multi-byte write, read, repeated START and
// reset during an address ACK.
module tb_i2c_slave;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk;
  logic       reset;
  logic       scl;
  logic       master_low;
  tri1        sda_bus;
  logic [7:0] tx_data;
  logic       rd_req;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rw;
  logic       busy;

  assign sda_bus = master_low ? 1'b0 : 1'bz;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda_bus),
    .tx_data    (tx_data),
    .rd_req     (rd_req),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rw         (rw),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int dv_cnt     = 0;
  int rd_cnt     = 0;
  int overlap    = 0;
  int last_dv_cyc   = 0;
  int last_rise_cyc = 0;
  int rise8         = 0;
  logic [7:0] dv_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_log.push_back(data_out);
      last_dv_cyc = cyc;
    end
    if (rd_req) rd_cnt++;
    if (data_valid && rd_req) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    tick(Q);
    master_low = ~b;
    tick(Q);
    scl = 1'b1;
    last_rise_cyc = cyc;
    tick(2 * Q);
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    tick(Q);
    master_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    b = sda_bus;
    tick(Q);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    tick(Q);
    master_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    master_low = 1'b1;
    tick(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q);
    master_low = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    master_low = 1'b0;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    rise8 = last_rise_cyc;
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
    logic       exp_busy;
    logic [7:0] exp_dout;
    int         exp_dv;
  } wr_vec_t;

  wr_vec_t tbl[5];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         dv0;
    int         rd0;
    int         n;

    tbl[0] = '{addr: 7'h50, data: 8'hA5, exp_ack: 1'b0, exp_busy: 1'b1, exp_dout: 8'hA5, exp_dv: 1};
    tbl[1] = '{addr: 7'h51, data: 8'h3C, exp_ack: 1'b1, exp_busy: 1'b0, exp_dout: 8'hA5, exp_dv: 0};
    tbl[2] = '{addr: 7'h50, data: 8'h00, exp_ack: 1'b0, exp_busy: 1'b1, exp_dout: 8'h00, exp_dv: 1};
    tbl[3] = '{addr: 7'h28, data: 8'hFF, exp_ack: 1'b1, exp_busy: 1'b0, exp_dout: 8'h00, exp_dv: 0};
    tbl[4] = '{addr: 7'h50, data: 8'hFF, exp_ack: 1'b0, exp_busy: 1'b1, exp_dout: 8'hFF, exp_dv: 1};

    reset      = 1'b1;
    scl        = 1'b1;
    master_low = 1'b0;
    tx_data    = 8'h00;
    tick(3);
    check("rst_sda", sda_bus, 1'b1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single-byte write transactions
    for (int i = 0; i < 5; i++) begin
      dv0 = dv_cnt;
      bus_start();
      write_byte({tbl[i].addr, 1'b0}, ack);
      check("tbl_addr_ack", ack, tbl[i].exp_ack);
      check("tbl_busy_mid", busy, tbl[i].exp_busy);
      write_byte(tbl[i].data, ack);
      check("tbl_data_ack", ack, tbl[i].exp_ack);
      bus_stop();
      tick(4);
      check("tbl_data_out", data_out, tbl[i].exp_dout);
      check("tbl_dv_count", dv_cnt - dv0, tbl[i].exp_dv);
      check("tbl_busy_end", busy, 1'b0);
      check("tbl_rw", rw, 1'b0);
    end
    check("dv_latency", last_dv_cyc - rise8, 3);

    // Multi-byte write
    dv0 = dv_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("mb_addr_ack", ack, 1'b0);
    write_byte(8'h11, ack);
    check("mb_ack1", ack, 1'b0);
    write_byte(8'h22, ack);
    check("mb_ack2", ack, 1'b0);
    write_byte(8'h33, ack);
    check("mb_ack3", ack, 1'b0);
    bus_stop();
    tick(4);
    check("mb_dv_count", dv_cnt - dv0, 3);
    n = dv_log.size();
    check("mb_byte1", dv_log[n-3], 8'h11);
    check("mb_byte2", dv_log[n-2], 8'h22);
    check("mb_byte3", dv_log[n-1], 8'h33);
    check("mb_data_out", data_out, 8'h33);

    // Two-byte read: ACK first, NACK second
    tx_data = 8'hC3;
    rd0 = rd_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_rw", rw, 1'b1);
    check("rd_busy", busy, 1'b1);
    read_byte(rd, 1'b0);
    check("rd_byte1", rd, 8'hC3);
    read_byte(rd, 1'b1);
    check("rd_byte2", rd, 8'hC3);
    master_low = 1'b0;
    tick(3);
    check("rd_sda_released", sda_bus, 1'b1);
    check("rd_busy_after_nack", busy, 1'b0);
    check("rd_req_count", rd_cnt - rd0, 2);
    bus_stop();
    tick(4);

    // Write then repeated START into a read
    tx_data = 8'h96;
    dv0 = dv_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 1'b0);
    write_byte(8'h7E, ack);
    check("rs_data_ack", ack, 1'b0);
    check("rs_data_out", data_out, 8'h7E);
    check("rs_rw_wr", rw, 1'b0);
    bus_start();
    write_byte(8'hA1, ack);
    check("rs_raddr_ack", ack, 1'b0);
    check("rs_rw_rd", rw, 1'b1);
    read_byte(rd, 1'b1);
    check("rs_read", rd, 8'h96);
    bus_stop();
    tick(4);
    check("rs_dv_count", dv_cnt - dv0, 1);
    check("rs_data_out_end", data_out, 8'h7E);

    // Reset while the address ACK is on the bus
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(1'b0 ^ (8'hA0 >> i) & 1'b1);
    master_low = 1'b0;
    tick(Q);
    check("rm_ack_driven", sda_bus, 1'b0);
    check("rm_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rm_sda", sda_bus, 1'b1);
    check("rm_busy", busy, 1'b0);
    check("rm_rw", rw, 1'b0);
    check("rm_data_out", data_out, 8'h00);
    check("rm_data_valid", data_valid, 1'b0);
    check("rm_rd_req", rd_req, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(3);
    bus_stop();
    tick(4);
    bus_start();
    write_byte(8'hA0, ack);
    check("rm_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    check("rm_data_ack", ack, 1'b0);
    bus_stop();
    tick(4);
    check("rm_data_out_after", data_out, 8'h5A);

    check("dv_rd_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
